// File: rtl/jac1_pkg.sv
// Shared definitions for the JAC1 program loader.
//   DATA_WIDTH : default byte / program-memory word width
//   SYNC_BYTE  : frame start marker
//   ld_state_e : loader FSM states
package jac1_pkg;

    localparam int         DATA_WIDTH = 8;
    localparam logic [7:0] SYNC_BYTE  = 8'hA5;

    localparam logic [2:0] LD_IDLE_ENC = 3'd0;
    localparam logic [2:0] LD_ADDR_ENC = 3'd1;
    localparam logic [2:0] LD_LEN_ENC  = 3'd2;
    localparam logic [2:0] LD_DATA_ENC = 3'd3;
    localparam logic [2:0] LD_CHK_ENC  = 3'd4;

    typedef enum logic [2:0] {
        LD_IDLE = LD_IDLE_ENC,
        LD_ADDR = LD_ADDR_ENC,
        LD_LEN  = LD_LEN_ENC,
        LD_DATA = LD_DATA_ENC,
        LD_CHK  = LD_CHK_ENC
    } ld_state_e;

endpackage

// File: rtl/jac1_chksum_acc.sv
// Modulo-2^Width checksum accumulator.
// Ports:
//   clk         : clock, rising edge
//   res_n_i     : synchronous active-low reset, clears the accumulator
//   clr_i       : clear accumulator (has priority over add)
//   add_i       : add data_i into the accumulator
//   data_i      : byte to add
//   next_zero_o : 1 when (accumulator + data_i) mod 2^Width is zero; lets the
//                 owner judge a final checksum byte in the same cycle it arrives
module jac1_chksum_acc
    import jac1_pkg::*;
#(
    parameter int Width = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             res_n_i,
    input  logic             clr_i,
    input  logic             add_i,
    input  logic [Width-1:0] data_i,
    output logic             next_zero_o
);

    logic [Width-1:0] acc_q;
    logic [Width-1:0] acc_d;
    logic [Width-1:0] sum;

    assign sum         = acc_q + data_i;
    assign next_zero_o = (sum == '0);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/jac1_prog_loader.sv
// Byte-stream program loader for the JAC1 core. Accepts frames of the form
// SYNC, ADDR, LEN, LEN data bytes, CHK over a valid/ready handshake, writes
// the data bytes into program memory and holds the core in reset until a
// frame with a good checksum has been loaded.
// Ports:
//   clk        : clock, rising edge
//   sys_res_n  : synchronous active-low reset
//   rx_valid   : input byte valid
//   rx_data    : input byte
//   rx_ready   : loader accepts a byte this cycle
//   mem_we     : program memory write strobe (one cycle per data byte)
//   mem_addr   : program memory write address
//   mem_wdata  : program memory write data
//   cpu_res_n  : active-low reset to the core
//   load_done  : last frame loaded with good checksum (sticky until next sync)
//   load_err   : last frame failed its checksum (sticky until next sync)
module jac1_prog_loader
    import jac1_pkg::*;
#(
    parameter int                   DataWidth = DATA_WIDTH,
    parameter int                   AddrWidth = 8,
    parameter logic [DataWidth-1:0] SyncByte  = SYNC_BYTE,
    parameter bit                   BootHold  = 1'b1
) (
    input  logic                 clk,
    input  logic                 sys_res_n,
    input  logic                 rx_valid,
    input  logic [DataWidth-1:0] rx_data,
    output logic                 rx_ready,
    output logic                 mem_we,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    output logic                 cpu_res_n,
    output logic                 load_done,
    output logic                 load_err
);

    ld_state_e            state_q, state_d;
    logic                 rx_ready_q, rx_ready_d;
    logic [AddrWidth-1:0] ptr_q, ptr_d;          // next write address
    logic [DataWidth-1:0] count_q, count_d;      // data bytes still expected
    logic                 mem_we_q, mem_we_d;
    logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
    logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
    logic                 cpu_res_n_q, cpu_res_n_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic accept;
    logic acc_clr;
    logic acc_add;
    logic chk_ok;

    assign accept = rx_valid && rx_ready_q;

    jac1_chksum_acc #(
        .Width (DataWidth)
    ) u_chksum (
        .clk         (clk),
        .res_n_i     (sys_res_n),
        .clr_i       (acc_clr),
        .add_i       (acc_add),
        .data_i      (rx_data),
        .next_zero_o (chk_ok)
    );

    always_comb begin
        state_d     = state_q;
        rx_ready_d  = 1'b1;
        ptr_d       = ptr_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_res_n_d = cpu_res_n_q;
        done_d      = done_q;
        err_d       = err_q;
        acc_clr     = 1'b0;
        acc_add     = 1'b0;

        if (accept) begin
            case (state_q)
                LD_IDLE: begin
                    // Anything other than the marker is line noise and dropped.
                    if (rx_data == SyncByte) begin
                        state_d     = LD_ADDR;
                        done_d      = 1'b0;
                        err_d       = 1'b0;
                        cpu_res_n_d = 1'b0;
                        acc_clr     = 1'b1;
                    end
                end
                LD_ADDR: begin
                    ptr_d   = AddrWidth'(rx_data);
                    acc_add = 1'b1;
                    state_d = LD_LEN;
                end
                LD_LEN: begin
                    count_d = rx_data;
                    acc_add = 1'b1;
                    state_d = (rx_data != '0) ? LD_DATA : LD_CHK;
                end
                LD_DATA: begin
                    acc_add     = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = rx_data;
                    ptr_d       = ptr_q + AddrWidth'(1);   // wraps naturally
                    count_d     = count_q - DataWidth'(1);
                    if (count_q == DataWidth'(1)) begin
                        state_d = LD_CHK;
                    end
                end
                LD_CHK: begin
                    // chk_ok already includes this CHK byte.
                    if (chk_ok) begin
                        done_d      = 1'b1;
                        cpu_res_n_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = LD_IDLE;
                end
                default: begin
                    state_d = LD_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_res_n) begin
            state_q     <= LD_IDLE;
            rx_ready_q  <= 1'b0;
            ptr_q       <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_res_n_q <= ~BootHold;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= rx_ready_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_res_n_q <= cpu_res_n_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_res_n = cpu_res_n_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_jac1_prog_loader.sv
// Self-checking bench for jac1_prog_loader. Each table row is one byte
// sequence with, per byte, the expected outputs one edge after acceptance.
module tb_jac1_prog_loader;

    logic       clk = 1'b0;
    logic       sys_res_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_res_n;
    logic       load_done;
    logic       load_err;

    jac1_prog_loader dut (
        .clk       (clk),
        .sys_res_n (sys_res_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_res_n (cpu_res_n),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              n;       // bytes in this sequence
        logic [0:7][7:0] b;       // the bytes
        logic [0:7]      we_m;    // expected mem_we after byte i
        logic [0:7]      cpu_m;   // expected cpu_res_n after byte i
        logic [0:7]      done_m;  // expected load_done after byte i
        logic [0:7]      err_m;   // expected load_err after byte i
        logic [0:3][7:0] wa;      // expected write addresses, in order
        logic [0:3][7:0] wd;      // expected write data, in order
    } vec_t;

    vec_t tbl [6];
    vec_t hv;

    int checks   = 0;
    int failures = 0;
    int cur_vec  = 0;
    int cur_idx  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d byte=%0d actual=%0h expected=%0h",
                     name, cur_vec, cur_idx, act, exp);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_rx_ready",  rx_ready,  0);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_res_n", cpu_res_n, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_load_err",  load_err,  0);
    endtask

    // Feed one sequence; optional random idle gaps between bytes.
    task automatic run_vec(input int id, input vec_t v, input bit gaps);
        int wi;
        int g;
        wi      = 0;
        cur_vec = id;
        for (int i = 0; i < v.n; i++) begin
            cur_idx = i;
            if (gaps) begin
                g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
                for (int k = 0; k < g; k++) begin
                    rx_valid = 1'b0;
                    rx_data  = 8'h5A;
                    @(posedge clk);
                    @(negedge clk);
                    chk("gap_mem_we", mem_we, 0);
                    if (i > 0) begin
                        chk("gap_cpu_res_n", cpu_res_n, v.cpu_m[i-1]);
                        chk("gap_load_done", load_done, v.done_m[i-1]);
                    end
                end
            end
            rx_valid = 1'b1;
            rx_data  = v.b[i];
            chk("rx_ready", rx_ready, 1);
            @(posedge clk);
            @(negedge clk);
            $display("xfer vec=%0d byte=%0d data=%02h we=%b addr=%02h wdata=%02h cpu_res_n=%b done=%b err=%b",
                     id, i, v.b[i], mem_we, mem_addr, mem_wdata, cpu_res_n, load_done, load_err);
            chk("mem_we", mem_we, v.we_m[i]);
            if (v.we_m[i]) begin
                chk("mem_addr",  mem_addr,  v.wa[wi]);
                chk("mem_wdata", mem_wdata, v.wd[wi]);
                wi++;
            end
            chk("cpu_res_n", cpu_res_n, v.cpu_m[i]);
            chk("load_done", load_done, v.done_m[i]);
            chk("load_err",  load_err,  v.err_m[i]);
        end
        // One idle cycle: a write strobe must not repeat.
        rx_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cur_idx = v.n;
        chk("idle_mem_we", mem_we, 0);
    endtask

    initial begin
        // Checksum bytes make ADDR+LEN+data+CHK == 0 mod 256.
        // Garbage then good frame: 10+02+01+02 = 15 -> CHK EB.
        tbl[0] = '{8, {8'h00, 8'h11, 8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'hEB},
                   8'b00000110, 8'b00000001, 8'b00000001, 8'b00000000,
                   {8'h10, 8'h11, 8'h00, 8'h00}, {8'h01, 8'h02, 8'h00, 8'h00}};
        // Bad checksum: writes still happen, core stays in reset.
        tbl[1] = '{6, {8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'hEE, 8'h00, 8'h00},
                   8'b00011000, 8'b00000000, 8'b00000000, 8'b00000100,
                   {8'h10, 8'h11, 8'h00, 8'h00}, {8'h01, 8'h02, 8'h00, 8'h00}};
        // Good frame again releases the core and clears load_err.
        tbl[2] = '{6, {8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'hEB, 8'h00, 8'h00},
                   8'b00011000, 8'b00000100, 8'b00000100, 8'b00000000,
                   {8'h10, 8'h11, 8'h00, 8'h00}, {8'h01, 8'h02, 8'h00, 8'h00}};
        // Address wrap: FF+02+AA+BB = 66 -> CHK 9A.
        tbl[3] = '{6, {8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h9A, 8'h00, 8'h00},
                   8'b00011000, 8'b00000100, 8'b00000100, 8'b00000000,
                   {8'hFF, 8'h00, 8'h00, 8'h00}, {8'hAA, 8'hBB, 8'h00, 8'h00}};
        // Zero length: no writes.
        tbl[4] = '{4, {8'hA5, 8'h20, 8'h00, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00},
                   8'b00000000, 8'b00010000, 8'b00010000, 8'b00000000,
                   {8'h00, 8'h00, 8'h00, 8'h00}, {8'h00, 8'h00, 8'h00, 8'h00}};
        // Sync value as payload: 30+01+A5 = D6 -> CHK 2A.
        tbl[5] = '{5, {8'hA5, 8'h30, 8'h01, 8'hA5, 8'h2A, 8'h00, 8'h00, 8'h00},
                   8'b00010000, 8'b00001000, 8'b00001000, 8'b00000000,
                   {8'h30, 8'h00, 8'h00, 8'h00}, {8'hA5, 8'h00, 8'h00, 8'h00}};

        sys_res_n = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cur_vec = -1;
        chk_reset_values();
        sys_res_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_rx_ready", rx_ready, 1);

        for (int t = 0; t < 6; t++) begin
            run_vec(t, tbl[t], 1'b0);
        end

        // Reset in the middle of a 4-byte data frame.
        hv = '{4, {8'hA5, 8'h40, 8'h04, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00},
               8'b00010000, 8'b00000000, 8'b00000000, 8'b00000000,
               {8'h40, 8'h00, 8'h00, 8'h00}, {8'h11, 8'h00, 8'h00, 8'h00}};
        run_vec(10, hv, 1'b0);
        sys_res_n = 1'b0;
        rx_valid  = 1'b1;
        rx_data   = 8'h22;
        @(posedge clk);
        @(negedge clk);
        cur_vec = 11;
        cur_idx = 0;
        $display("xfer vec=11 reset mid-frame cpu_res_n=%b we=%b", cpu_res_n, mem_we);
        chk_reset_values();
        sys_res_n = 1'b1;
        rx_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Leftover payload after reset is noise in IDLE: no writes.
        hv = '{2, {8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               8'b00000000, 8'b00000000, 8'b00000000, 8'b00000000,
               {8'h00, 8'h00, 8'h00, 8'h00}, {8'h00, 8'h00, 8'h00, 8'h00}};
        run_vec(12, hv, 1'b0);
        // Fresh frame: 50+02+07+08 = 61 -> CHK 9F.
        hv = '{6, {8'hA5, 8'h50, 8'h02, 8'h07, 8'h08, 8'h9F, 8'h00, 8'h00},
               8'b00011000, 8'b00000100, 8'b00000100, 8'b00000000,
               {8'h50, 8'h51, 8'h00, 8'h00}, {8'h07, 8'h08, 8'h00, 8'h00}};
        run_vec(13, hv, 1'b0);

        // Same good frame with random valid gaps.
        run_vec(14, tbl[2], 1'b1);
        run_vec(15, tbl[2], 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
